// File: rtl/e_mdu.sv
// E-stage multi-cycle multiply/divide unit owning the HI/LO pair.
// Results are computed into shadow registers at issue and exposed when the latency counter expires.
module e_mdu #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             Start,
  input  logic [2:0]       MDU_Op,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             Cancel,
  output logic             Busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0]    MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0]    DIV_LOAD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
  localparam logic [CW-1:0]    CNT_ZERO  = {CW{1'b0}};
  localparam logic [WIDTH-1:0] ZERO_W    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {
    IDLE_S = 1'b0,
    RUN_S  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] sh_hi_q, sh_hi_d, sh_lo_q, sh_lo_d;
  logic             sh_wr_q, sh_wr_d;
  logic             busy_q, busy_d;

  logic signed [2*WIDTH-1:0] sext_a, sext_b;
  logic [2*WIDTH-1:0]        mul_s_res, mul_u_res;
  logic [WIDTH-1:0]          div_q, div_r, divu_q, divu_r;
  logic                      div_zero, div_ovf;

  assign sext_a    = {{WIDTH{SrcA[WIDTH-1]}}, SrcA};
  assign sext_b    = {{WIDTH{SrcB[WIDTH-1]}}, SrcB};
  assign mul_s_res = sext_a * sext_b;
  assign mul_u_res = {{WIDTH{1'b0}}, SrcA} * {{WIDTH{1'b0}}, SrcB};
  assign div_zero  = (SrcB == ZERO_W);
  assign div_ovf   = (SrcA == MIN_NEG) && (SrcB == {WIDTH{1'b1}});

  // Quotient/remainder; the overflow case is pinned so it never depends on tool wrap behaviour.
  always_comb begin
    div_q  = ZERO_W;
    div_r  = ZERO_W;
    divu_q = ZERO_W;
    divu_r = ZERO_W;
    if (!div_zero) begin
      divu_q = SrcA / SrcB;
      divu_r = SrcA % SrcB;
      if (div_ovf) begin
        div_q = MIN_NEG;
        div_r = ZERO_W;
      end else begin
        div_q = $signed(SrcA) / $signed(SrcB);
        div_r = $signed(SrcA) % $signed(SrcB);
      end
    end else begin
      div_q = ZERO_W;
      div_r = ZERO_W;
    end
  end

  // Next-state: issue, countdown, completion and cancel.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sh_hi_d = sh_hi_q;
    sh_lo_d = sh_lo_q;
    sh_wr_d = sh_wr_q;
    case (state_q)
      IDLE_S: begin
        if (Start && !Cancel) begin
          case (MDU_Op)
            3'b000: begin
              state_d = RUN_S;
              cnt_d   = MULT_LOAD;
              {sh_hi_d, sh_lo_d} = mul_s_res;
              sh_wr_d = 1'b1;
            end
            3'b001: begin
              state_d = RUN_S;
              cnt_d   = MULT_LOAD;
              {sh_hi_d, sh_lo_d} = mul_u_res;
              sh_wr_d = 1'b1;
            end
            3'b010: begin
              state_d = RUN_S;
              cnt_d   = DIV_LOAD;
              sh_hi_d = div_r;
              sh_lo_d = div_q;
              sh_wr_d = !div_zero;
            end
            3'b011: begin
              state_d = RUN_S;
              cnt_d   = DIV_LOAD;
              sh_hi_d = divu_r;
              sh_lo_d = divu_q;
              sh_wr_d = !div_zero;
            end
            3'b100:  hi_d = SrcA;
            3'b101:  lo_d = SrcA;
            default: state_d = IDLE_S;
          endcase
        end else begin
          state_d = IDLE_S;
        end
      end
      RUN_S: begin
        if (Cancel) begin
          state_d = IDLE_S;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_ONE) begin
          state_d = IDLE_S;
          cnt_d   = CNT_ZERO;
          if (sh_wr_q) begin
            hi_d = sh_hi_q;
            lo_d = sh_lo_q;
          end else begin
            hi_d = hi_q;
            lo_d = lo_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE_S;
        cnt_d   = CNT_ZERO;
      end
    endcase
    busy_d = (state_d == RUN_S);
  end

  // State, counter, shadow and architectural registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE_S;
      cnt_q   <= CNT_ZERO;
      hi_q    <= ZERO_W;
      lo_q    <= ZERO_W;
      sh_hi_q <= ZERO_W;
      sh_lo_q <= ZERO_W;
      sh_wr_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sh_hi_q <= sh_hi_d;
      sh_lo_q <= sh_lo_d;
      sh_wr_q <= sh_wr_d;
      busy_q  <= busy_d;
    end
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Directed plus randomized bench for e_mdu against an arithmetic reference model.
module tb_e_mdu;
  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         Start = 1'b0;
  logic         Cancel = 1'b0;
  logic [2:0]   MDU_Op = 3'd0;
  logic [W-1:0] SrcA = '0;
  logic [W-1:0] SrcB = '0;
  logic         Busy;
  logic [W-1:0] HI, LO;

  int           compared = 0;
  int           mismatched = 0;
  logic [W-1:0] hi_m = '0;
  logic [W-1:0] lo_m = '0;
  logic [2:0]   inj_op = 3'd5;
  logic [W-1:0] inj_a = 32'h5;

  e_mdu #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset_n(reset_n), .Start(Start), .MDU_Op(MDU_Op),
    .SrcA(SrcA), .SrcB(SrcB), .Cancel(Cancel), .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: results from magnitudes and signs, not from the RTL's operators.
  function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output bit wr, output logic [W-1:0] nh, output logic [W-1:0] nl,
                                output int cyc);
    longint sa, sb, ma, mb, q, r;
    logic [2*W-1:0] p;
    wr = 1'b1; cyc = 0; p = '0;
    nh = hi_m; nl = lo_m;
    case (op)
      3'd0: begin
        sa = longint'($signed(a)); sb = longint'($signed(b));
        p = 64'(sa * sb); cyc = MC; {nh, nl} = p;
      end
      3'd1: begin
        p = {32'd0, a} * {32'd0, b}; cyc = MC; {nh, nl} = p;
      end
      3'd2: begin
        cyc = DC;
        if (b == 32'd0) wr = 1'b0;
        else begin
          sa = longint'($signed(a)); sb = longint'($signed(b));
          ma = (sa < 0) ? -sa : sa; mb = (sb < 0) ? -sb : sb;
          q = ma / mb; r = ma % mb;
          if ((sa < 0) != (sb < 0)) q = -q;
          if (sa < 0) r = -r;
          nh = r[W-1:0]; nl = q[W-1:0];
        end
      end
      3'd3: begin
        cyc = DC;
        if (b == 32'd0) wr = 1'b0;
        else begin
          nh = a % b; nl = a / b;
        end
      end
      3'd4: nh = a;
      3'd5: nl = a;
      default: wr = 1'b0;
    endcase
  endfunction

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    Start = 1'b1; MDU_Op = op; SrcA = a; SrcB = b;
    @(posedge clk); #1;
    Start = 1'b0;
  endtask

  // inj>0 drives a stray Start on that busy cycle; it must be ignored.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int inj);
    bit wr; logic [W-1:0] nh, nl; int cyc, n;
    model(op, a, b, wr, nh, nl, cyc);
    issue(op, a, b);
    n = 0;
    while (Busy === 1'b1 && n < 200) begin
      n++;
      if (n == inj) begin
        Start = 1'b1; MDU_Op = inj_op; SrcA = inj_a; SrcB = $urandom;
      end
      @(posedge clk); #1;
      Start = 1'b0;
    end
    check({tag, "_busy"}, W'(n), W'(cyc));
    if (wr) begin hi_m = nh; lo_m = nl; end
    check({tag, "_hi"}, HI, hi_m);
    check({tag, "_lo"}, LO, lo_m);
  endtask

  task automatic cancel_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input int k);
    issue(op, a, b);
    repeat (k - 1) begin @(posedge clk); #1; end
    check({tag, "_busy_pre"}, W'(Busy), W'(1));
    Cancel = 1'b1;
    @(posedge clk); #1;
    Cancel = 1'b0;
    check({tag, "_busy_post"}, W'(Busy), W'(0));
    check({tag, "_hi"}, HI, hi_m);
    check({tag, "_lo"}, LO, lo_m);
  endtask

  initial begin
    logic [2:0] op;
    logic [W-1:0] a, b;
    int n_cyc, sel;

    #3;
    check("rst_busy", W'(Busy), W'(0));
    check("rst_hi", HI, 32'h0);
    check("rst_lo", LO, 32'h0);
    @(negedge clk); reset_n = 1'b1;

    run_op("mult", 3'd0, 32'hFFFFFFFF, 32'h2, 0);
    check("mult_hi_k", HI, 32'hFFFFFFFF);
    check("mult_lo_k", LO, 32'hFFFFFFFE);
    run_op("multu", 3'd1, 32'hFFFFFFFF, 32'h2, 0);
    check("multu_hi_k", HI, 32'h1);
    check("multu_lo_k", LO, 32'hFFFFFFFE);

    run_op("div", 3'd2, 32'hFFFFFFF9, 32'h2, 0);
    check("div_lo_k", LO, 32'hFFFFFFFD);
    check("div_hi_k", HI, 32'hFFFFFFFF);
    run_op("divu", 3'd3, 32'h7, 32'h2, 0);
    check("divu_lo_k", LO, 32'h3);
    check("divu_hi_k", HI, 32'h1);

    run_op("mthi11", 3'd4, 32'h11, 32'h0, 0);
    run_op("mtlo22", 3'd5, 32'h22, 32'h0, 0);
    run_op("divu0", 3'd3, 32'h5, 32'h0, 0);
    check("divu0_hi_k", HI, 32'h11);
    check("divu0_lo_k", LO, 32'h22);
    run_op("divovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 0);
    check("divovf_lo_k", LO, 32'h80000000);
    check("divovf_hi_k", HI, 32'h0);

    cancel_op("cancel", 3'd0, 32'h3, 32'h4, 2);
    check("cancel_hi_k", HI, 32'h0);
    check("cancel_lo_k", LO, 32'h80000000);
    run_op("mult34", 3'd0, 32'h3, 32'h4, 0);
    check("mult34_lo_k", LO, 32'hC);
    check("mult34_hi_k", HI, 32'h0);

    run_op("mthi", 3'd4, 32'hABCD, 32'h0, 0);
    check("mthi_k", HI, 32'hABCD);
    @(posedge clk); #1;
    check("mthi_busy2", W'(Busy), W'(0));
    run_op("nop6", 3'd6, 32'h1234, 32'h1, 0);
    run_op("nop7", 3'd7, 32'h1234, 32'h1, 0);

    inj_op = 3'd5; inj_a = 32'h5;
    run_op("div_inj", 3'd2, 32'd100, 32'd7, 3);
    check("div_inj_lo_k", LO, 32'd14);
    run_op("mult_inj_end", 3'd0, 32'd6, 32'd7, MC);

    issue(3'd0, 32'h9, 32'h9);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    check("rstmid_busy", W'(Busy), W'(0));
    check("rstmid_hi", HI, 32'h0);
    check("rstmid_lo", LO, 32'h0);
    hi_m = '0; lo_m = '0;
    @(negedge clk); reset_n = 1'b1;
    run_op("post_rst", 3'd1, 32'h10, 32'h10, 0);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom; b = $urandom;
      sel = $urandom_range(0, 4);
      if (sel == 0) b = 32'($urandom_range(0, 3));
      else if (sel == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      else if (sel == 2) begin a = 32'($urandom_range(0, 50)); b = -32'($urandom_range(1, 9)); end
      n_cyc = (op < 3'd2) ? MC : DC;
      inj_op = 3'($urandom_range(0, 7)); inj_a = $urandom;
      if (op < 3'd4 && $urandom_range(0, 3) == 0)
        cancel_op("rnd_cancel", op, a, b, $urandom_range(1, n_cyc - 1));
      else if (op < 3'd4 && $urandom_range(0, 1) == 1)
        run_op("rnd_inj", op, a, b, $urandom_range(1, n_cyc));
      else
        run_op("rnd", op, a, b, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/e_mdu.md
# e_mdu

Parametrised multi-cycle multiply/divide unit for the E stage. It sits beside the combinational ALU and owns the HI/LO register pair. It executes signed and unsigned multiply/divide with configurable latency and handles direct HI/LO writes. It exposes a registered Busy flag that the hazard unit uses to stall.

## Interface
Parameters:
- WIDTH, 32, operand and HI/LO width (≥ 2)
- MULT_CYCLES, 5, cycles Busy stays high for mult/multu (≥ 1)
- DIV_CYCLES, 10, cycles Busy stays high for div/divu (≥ 1)

Ports:
- clk  input  1  clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- Start  input  1  qualifies MDU_Op this cycle
- MDU_Op  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, others no-op
- SrcA  input  WIDTH  rs operand (dividend / multiplicand / mthi-mtlo data)
- SrcB  input  WIDTH  rt operand (divisor / multiplier)
- Cancel  input  1  abort in-flight operation (exception flush)
- Busy  output  1  registered; high while an operation is in flight
- HI  output  WIDTH  HI register
- LO  output  WIDTH  LO register

## Operation
- Reset is asynchronous, active-low, and independent of clk. While reset_n=0: HI=0, LO=0, Busy=0, internal counter=0, shadow results=0.
- States:
  - IDLE: Busy=0.
  - RUN: Busy=1, counter > 0.
- IDLE → RUN on an accepted Start with MDU_Op in {mult, multu, div, divu}:
  - Operands are captured on that edge; the 2·WIDTH result is computed into shadow registers.
  - The counter loads MULT_CYCLES or DIV_CYCLES.
- RUN: the counter decrements each edge. On the edge where the counter goes 1 → 0, HI/LO load from the shadow registers and the unit returns to IDLE.
- mult: {HI,LO} = signed(SrcA) × signed(SrcB), full 2·WIDTH product.
- multu: {HI,LO} = unsigned product, full 2·WIDTH product.
- div: LO = signed quotient truncated toward zero; HI = remainder, which takes the sign of the dividend.
- divu: LO = unsigned quotient; HI = unsigned remainder.
- Divisor = 0 (div or divu): the operation runs its full DIV_CYCLES; HI and LO are left unchanged at completion.
- div of −2^(WIDTH−1) by −1: LO = −2^(WIDTH−1), HI = 0.
- mthi / mtlo with Start=1 in IDLE: HI (or LO) = SrcA on that edge. Busy stays 0.
- Start while in RUN: ignored (no capture, no HI/LO write). The hazard unit must stall instead.
- Cancel=1 in RUN: on the next edge the counter clears and Busy=0; HI/LO keep their pre-operation values.
- Cancel has priority over a same-edge Start: the Start is dropped.
- Cancel=1 in IDLE: no effect.
- Completion and Start on the same edge (counter=1 and Start=1 with Cancel=0): completion writes HI/LO. The Start is ignored because the unit is still in RUN on that edge.
- No-op MDU_Op codes with Start=1: no state change.

## Timing
- Start sampled at edge t0 for an N-cycle op:
  - Busy=1 from just after t0 through the cycle ending at edge t0+N.
  - HI/LO carry the new value and Busy=0 just after t0+N.
- The unit reads as busy for exactly N visible cycles. N = MULT_CYCLES or DIV_CYCLES.
- mthi/mtlo: the new value is visible one cycle after the Start edge, with zero Busy cycles.
- HI/LO are registered outputs with no combinational path from SrcA/SrcB.
- Busy is registered and has no combinational path from Start. The external stall equation is Start_MD | Busy.
- Reset asserted mid-operation clears everything immediately (asynchronous reset). The first Start after reset_n deasserts is accepted normally.

## Test plan
- Reset: assert reset_n=0 mid-RUN → Busy, HI and LO read 0 immediately, before the next clk edge.
- mult: mult 0xFFFFFFFF × 0x00000002 (WIDTH=32) → Busy high for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. The same operands with multu → HI=0x00000001, LO=0xFFFFFFFE.
- Signed and unsigned divide:
  - div −7 / 2 → after 10 busy cycles, LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1).
  - divu 7 / 2 → LO=3, HI=1.
- Divide corner cases, with HI=0x11, LO=0x22 preloaded:
  - divu 5 / 0 → Busy for 10 cycles; HI=0x11, LO=0x22 unchanged.
  - div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- Cancel: mult 3×4 with Cancel pulsed at busy cycle 2 → Busy=0 on the next cycle; HI/LO keep their old values.
  - A later full mult 3×4 → LO=12, HI=0.
- Direct writes and Start during RUN:
  - mthi 0xABCD → HI=0xABCD on the next cycle, Busy never rises.
  - A Start(mtlo 0x5) issued during a running div → LO is not written by the mtlo.
